// File: rtl/virtio_mem_bridge_if.sv
// AXI4-Lite master channel bundle used between the virtio memory bridge and its slave.
// The master modport is the bridge side; the slave modport is the memory/interconnect side.
interface virtio_mem_bridge_if;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [2:0]  m_arprot;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [2:0]  m_awprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  modport master (
    output m_araddr, m_arvalid, m_arprot, m_rready,
    output m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_arready, m_rdata, m_rresp, m_rvalid,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    input  m_araddr, m_arvalid, m_arprot, m_rready,
    input  m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_arready, m_rdata, m_rresp, m_rvalid,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/virtio_mem_bridge.sv
// Single-outstanding bridge from the virtio engine's strobe-based memory port to AXI4-Lite.
// Reads and writes each complete with a one-cycle mem_response_enable pulse.
module virtio_mem_bridge #(
  parameter logic [31:0] BASE_OFFSET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_request_enable,
  input  logic        mem_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mem_data,
  output logic        bus_error,
  output logic        req_dropped,
  virtio_mem_bridge_if.master m
);

  typedef enum logic [2:0] {
    StIdle, StRdAddr, StRdData, StWrReq, StWrResp, StResp
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        bus_error_q, bus_error_d;
  logic        req_dropped_q, req_dropped_d;
  logic        arvalid, rready, awvalid, wvalid, bready, resp;

  always_comb begin
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    mem_data_d    = mem_data_q;
    bus_error_d   = bus_error_q;
    req_dropped_d = req_dropped_q | (mem_request_enable && (state_q != StIdle));
    arvalid       = 1'b0;
    rready        = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    resp          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_request_enable) begin
          state_d   = mem_mode ? StWrReq : StRdAddr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StRdAddr: begin
        arvalid = 1'b1;
        if (m.m_arready) state_d = StRdData;
      end
      StRdData: begin
        rready = 1'b1;
        if (m.m_rvalid) begin
          mem_data_d  = m.m_rdata;
          bus_error_d = bus_error_q | (m.m_rresp != 2'b00);
          state_d     = StResp;
        end
      end
      StWrReq: begin
        // AW and W retire independently; leave only when both have handshaken.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | m.m_awready;
        w_done_d  = w_done_q | m.m_wready;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        bready = 1'b1;
        if (m.m_bvalid) begin
          mem_data_d  = 32'h0;
          bus_error_d = bus_error_q | (m.m_bresp != 2'b00);
          state_d     = StResp;
        end
      end
      StResp: begin
        resp    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      mem_data_q    <= 32'h0;
      bus_error_q   <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      mem_data_q    <= mem_data_d;
      bus_error_q   <= bus_error_d;
      req_dropped_q <= req_dropped_d;
      if (state_q == StIdle && mem_request_enable) begin
        addr_q  <= mem_addr + BASE_OFFSET;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
    end
  end

  assign m.m_araddr  = addr_q;
  assign m.m_arvalid = arvalid;
  assign m.m_arprot  = 3'b000;
  assign m.m_rready  = rready;
  assign m.m_awaddr  = addr_q;
  assign m.m_awvalid = awvalid;
  assign m.m_awprot  = 3'b000;
  assign m.m_wdata   = wdata_q;
  assign m.m_wstrb   = wstrb_q;
  assign m.m_wvalid  = wvalid;
  assign m.m_bready  = bready;

  assign mem_response_enable = resp;
  assign mem_data            = mem_data_q;
  assign bus_error           = bus_error_q;
  assign req_dropped         = req_dropped_q;

endmodule

// File: tb/tb_virtio_mem_bridge.sv
// Directed plus randomized bench for virtio_mem_bridge; a cycle-stepped AXI slave and a
// transaction-level model (sticky flags, handshake and response counts) supply expectations.
module tb_virtio_mem_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, mode;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        resp0, resp1, berr0, berr1, drop0, drop1;
  logic [31:0] mdata0, mdata1;

  int checks = 0;
  int errors = 0;
  bit exp_berr, exp_drop;
  int exp_reads = 0, exp_writes = 0, exp_resps = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, resp_cnt = 0;

  virtio_mem_bridge_if bus0 ();
  virtio_mem_bridge_if bus1 ();

  // The wrap-test instance sees the same slave inputs; only its outputs differ.
  assign bus1.m_arready = bus0.m_arready;
  assign bus1.m_rdata   = bus0.m_rdata;
  assign bus1.m_rresp   = bus0.m_rresp;
  assign bus1.m_rvalid  = bus0.m_rvalid;
  assign bus1.m_awready = bus0.m_awready;
  assign bus1.m_wready  = bus0.m_wready;
  assign bus1.m_bresp   = bus0.m_bresp;
  assign bus1.m_bvalid  = bus0.m_bvalid;

  virtio_mem_bridge #(.BASE_OFFSET(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .mem_request_enable(req), .mem_mode(mode), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_response_enable(resp0), .mem_data(mdata0),
    .bus_error(berr0), .req_dropped(drop0), .m(bus0)
  );

  virtio_mem_bridge #(.BASE_OFFSET(32'h8000_0000)) dut1 (
    .clk(clk), .rst(rst), .mem_request_enable(req), .mem_mode(mode), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_response_enable(resp1), .mem_data(mdata1),
    .bus_error(berr1), .req_dropped(drop1), .m(bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus0.m_arvalid && bus0.m_arready) ar_hs <= ar_hs + 1;
      if (bus0.m_awvalid && bus0.m_awready) aw_hs <= aw_hs + 1;
      if (bus0.m_wvalid && bus0.m_wready)   w_hs  <= w_hs + 1;
      if (resp0) resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] rr,
                         input int ar_d, input int r_d, input bit inject);
    req = 1'b1; mode = 1'b0; addr = a; wdata = $urandom; wstrb = 4'($urandom);
    step();
    req = 1'b0;
    chk("ar_valid", bus0.m_arvalid, 1);
    chk("ar_addr", bus0.m_araddr, a);
    chk("ar_addr_wrap", bus1.m_araddr, a + 32'h8000_0000);
    chk("ar_prot", bus0.m_arprot, 0);
    for (int i = 0; i < ar_d; i++) begin
      step();
      chk("ar_valid_hold", bus0.m_arvalid, 1);
      chk("ar_addr_hold", bus0.m_araddr, a);
    end
    bus0.m_arready = 1'b1;
    step();
    bus0.m_arready = 1'b0;
    chk("ar_valid_off", bus0.m_arvalid, 0);
    chk("r_ready", bus0.m_rready, 1);
    for (int i = 0; i < r_d; i++) begin
      if (inject && i == 0) begin
        req = 1'b1; mode = 1'($urandom); addr = $urandom;
      end
      step();
      req = 1'b0;
      if (inject && i == 0) exp_drop = 1'b1;
      chk("r_ready_hold", bus0.m_rready, 1);
      chk("ar_no_reissue", bus0.m_arvalid, 0);
    end
    bus0.m_rvalid = 1'b1; bus0.m_rdata = rd; bus0.m_rresp = rr;
    step();
    bus0.m_rvalid = 1'b0; bus0.m_rdata = $urandom; bus0.m_rresp = 2'b00;
    if (rr != 2'b00) exp_berr = 1'b1;
    exp_reads++; exp_resps++;
    chk("rd_resp", resp0, 1);
    chk("rd_data", mdata0, rd);
    chk("bus_error", berr0, exp_berr);
    chk("req_dropped", drop0, exp_drop);
    step();
    chk("rd_resp_pulse", resp0, 0);
    chk("idle_ar", bus0.m_arvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_d, input int w_d, input int b_d, input logic [1:0] br,
                          input bit abort);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    req = 1'b1; mode = 1'b1; addr = a; wdata = d; wstrb = s;
    step();
    req = 1'b0;
    chk("aw_addr", bus0.m_awaddr, a);
    chk("w_data", bus0.m_wdata, d);
    chk("w_strb", bus0.m_wstrb, {28'h0, s});
    chk("aw_prot", bus0.m_awprot, 0);
    for (int c = 0; !(aw_done && w_done) && c < 20; c++) begin
      chk("aw_valid", bus0.m_awvalid, {31'h0, !aw_done});
      chk("w_valid", bus0.m_wvalid, {31'h0, !w_done});
      chk("b_ready_early", bus0.m_bready, 0);
      bus0.m_awready = (c == aw_d);
      bus0.m_wready  = (c == w_d);
      step();
      if (c == aw_d) aw_done = 1'b1;
      if (c == w_d)  w_done = 1'b1;
      bus0.m_awready = 1'b0;
      bus0.m_wready  = 1'b0;
    end
    exp_writes++;
    chk("b_ready", bus0.m_bready, 1);
    chk("aw_valid_off", bus0.m_awvalid, 0);
    chk("w_valid_off", bus0.m_wvalid, 0);
    if (abort) begin
      #2 rst = 1'b1;
      #1;
      chk("abort_bready", bus0.m_bready, 0);
      chk("abort_valids", {bus0.m_arvalid, bus0.m_awvalid, bus0.m_wvalid, bus0.m_rready}, 0);
      chk("abort_resp", resp0, 0);
      chk("abort_mdata", mdata0, 0);
      chk("abort_awaddr", bus0.m_awaddr, 0);
      chk("abort_wdata", bus0.m_wdata, 0);
      chk("abort_flags", {berr0, drop0}, 0);
      exp_berr = 1'b0; exp_drop = 1'b0;
      step();
      chk("abort_no_resp", resp0, 0);
      rst = 1'b0;
      return;
    end
    for (int i = 0; i < b_d; i++) begin
      step();
      chk("b_ready_hold", bus0.m_bready, 1);
    end
    bus0.m_bvalid = 1'b1; bus0.m_bresp = br;
    step();
    bus0.m_bvalid = 1'b0; bus0.m_bresp = 2'b00;
    if (br != 2'b00) exp_berr = 1'b1;
    exp_resps++;
    chk("wr_resp", resp0, 1);
    chk("wr_data_zero", mdata0, 0);
    chk("bus_error", berr0, exp_berr);
    chk("req_dropped", drop0, exp_drop);
    step();
    chk("wr_resp_pulse", resp0, 0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; mode = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    bus0.m_arready = 1'b0; bus0.m_rdata = '0; bus0.m_rresp = 2'b00; bus0.m_rvalid = 1'b0;
    bus0.m_awready = 1'b0; bus0.m_wready = 1'b0; bus0.m_bresp = 2'b00; bus0.m_bvalid = 1'b0;
    exp_berr = 1'b0; exp_drop = 1'b0;
    step();
    step();
    chk("rst_valids", {bus0.m_arvalid, bus0.m_awvalid, bus0.m_wvalid}, 0);
    chk("rst_readies", {bus0.m_rready, bus0.m_bready}, 0);
    chk("rst_resp", resp0, 0);
    chk("rst_mdata", mdata0, 0);
    chk("rst_addr", bus0.m_araddr, 0);
    chk("rst_wdata", bus0.m_wdata, 0);
    chk("rst_wstrb", bus0.m_wstrb, 0);
    chk("rst_flags", {berr0, drop0}, 0);
    rst = 1'b0;

    // Request on the very first edge after reset release, zero-wait slave.
    do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0, 0, 1'b0);
    do_write($urandom, 32'h1234_5678, 4'b0011, 0, 3, 0, 2'b00, 1'b0);
    do_write($urandom, $urandom, 4'hF, 0, 0, 0, 2'b00, 1'b0);
    do_write($urandom, $urandom, 4'hC, 2, 0, 1, 2'b00, 1'b0);
    do_read($urandom, $urandom, 2'b10, 1, 1, 1'b0);
    do_read($urandom, $urandom, 2'b00, 0, 0, 1'b0);
    do_write($urandom, $urandom, 4'h1, 1, 1, 0, 2'b00, 1'b0);
    do_read($urandom, 32'hCAFE_F00D, 2'b00, 0, 2, 1'b1);
    do_read(32'h9000_0000, $urandom, 2'b00, 0, 0, 1'b0);
    do_write($urandom, $urandom, 4'h6, 0, 0, 2, 2'b00, 1'b1);
    do_read($urandom, $urandom, 2'b00, 0, 0, 1'b0);
    do_write($urandom, $urandom, 4'h9, 0, 0, 0, 2'b11, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [1:0] rsp;
      int r_d;
      rsp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_d = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0)
        do_read($urandom, $urandom, rsp, $urandom_range(0, 3), r_d,
                (r_d > 0) && ($urandom_range(0, 3) == 0));
      else
        do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), rsp, 1'b0);
    end

    step();
    chk("ar_handshakes", ar_hs, exp_reads);
    chk("aw_handshakes", aw_hs, exp_writes);
    chk("w_handshakes", w_hs, exp_writes);
    chk("responses", resp_cnt, exp_resps);
    chk("wrap_resp_count_match", resp1, resp0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
